// File: rtl/pkt_tx_gen_pkg.sv
// Shared types, limits and helpers for the packet transmit generator.
package pkt_tx_gen_pkg;

  localparam int MAX_LEN = 16383;
  localparam int MIN_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  // Word index width: a frame of MAX_LEN bytes spans up to 2^(LEN_W-3) words.
  localparam int WIDX_W  = LEN_W - 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    IPG  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Lane enables for the eop word; bit 7 is byte lane 0 (data[63:56]).
  // mod = 0 means the whole word is valid.
  function automatic logic [7:0] lane_mask(input logic [2:0] mod);
    logic [7:0] m;
    m = 8'hFF >> mod;
    return (mod == 3'd0) ? 8'hFF : ~m;
  endfunction

endpackage

// File: rtl/pkt_tx_gen_if.sv
// MAC transmit packet interface bundle.
// Handshake: a word transfers on every clock edge where val=1; the sink
// cannot refuse a word already presented. full is back-pressure sampled by
// the source at each edge; the sink must keep at least one word of margin
// so the word loaded on the edge that sees full=1 is still accepted.
interface pkt_tx_gen_if;
  logic [63:0] data;
  logic        val;
  logic        sop;
  logic        eop;
  logic [2:0]  mod;
  logic        full;

  modport master (output data, val, sop, eop, mod, input full);
  modport slave  (input data, val, sop, eop, mod, output full);
endinterface

// File: rtl/pkt_tx_gen_pattern.sv
// Combinational payload generator: byte b of frame p is (p + b) mod 256,
// with lanes beyond the frame length zeroed in the final word.
module pkt_tx_gen_pattern
  import pkt_tx_gen_pkg::*;
(
  input  logic [7:0]        pkt_idx,
  input  logic [WIDX_W-1:0] word_idx,
  input  logic [LEN_W-1:0]  len,
  output logic [63:0]       data
);

  logic [LEN_W-1:0]  len_m1;
  logic [WIDX_W-1:0] last_idx;
  logic [7:0]        lanes;

  assign len_m1   = len - LEN_W'(1);
  assign last_idx = len_m1[LEN_W-1:3];
  assign lanes    = (word_idx == last_idx) ? lane_mask(len[2:0]) : 8'hFF;

  // Lane i carries byte 8*w+i; only the low 5 bits of w matter mod 256.
  always_comb begin
    data = '0;
    for (int i = 0; i < 8; i++) begin
      if (lanes[7-i]) begin
        data[63-8*i -: 8] = pkt_idx + {word_idx[4:0], 3'(i)};
      end
    end
  end

endmodule

// File: rtl/pkt_tx_gen.sv
// Packet source for the MAC transmit interface: emits cfg_num fixed-length
// frames (or runs until stop) with a deterministic byte pattern, honouring
// pkt_tx_full back-pressure and a programmable inter-packet gap.
module pkt_tx_gen
  import pkt_tx_gen_pkg::*;
(
  input  logic             clk_156m25,
  input  logic             reset_156m25_n,
  input  logic             start,
  input  logic             stop,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [15:0]      cfg_num,
  input  logic [7:0]       cfg_ipg,
  pkt_tx_gen_if.master     pkt_tx,
  output logic             busy,
  output logic             done,
  output logic [31:0]      pkt_count,
  output state_t           dbg_state
);

  localparam logic [LEN_W-1:0] MIN_LEN_V = LEN_W'(MIN_LEN);

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [15:0]       num_q;
  logic [7:0]        ipg_q;
  logic [7:0]        ipg_cnt;
  logic [WIDX_W-1:0] w_q;
  logic [LEN_W-1:0]  len_m1;
  logic [WIDX_W-1:0] last_w;
  logic              is_last;
  logic              run_end;
  logic [63:0]       word;

  assign len_m1    = len_q - LEN_W'(1);
  assign last_w    = len_m1[LEN_W-1:3];
  assign is_last   = (w_q == last_w);
  // Evaluated on the eop edge: pkt_count has not yet counted this frame.
  assign run_end   = stop || ((num_q != 16'd0) && ((pkt_count + 32'd1) == {16'd0, num_q}));
  assign dbg_state = state;

  // The current frame index is simply the number of frames already finished.
  pkt_tx_gen_pattern u_pattern (
    .pkt_idx  (pkt_count[7:0]),
    .word_idx (w_q),
    .len      (len_q),
    .data     (word)
  );

  // Run control FSM with all outputs registered.
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state       <= IDLE;
      len_q       <= MIN_LEN_V;
      num_q       <= '0;
      ipg_q       <= '0;
      ipg_cnt     <= '0;
      w_q         <= '0;
      pkt_tx.data <= '0;
      pkt_tx.val  <= 1'b0;
      pkt_tx.sop  <= 1'b0;
      pkt_tx.eop  <= 1'b0;
      pkt_tx.mod  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pkt_count   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          pkt_tx.val <= 1'b0;
          pkt_tx.sop <= 1'b0;
          pkt_tx.eop <= 1'b0;
          pkt_tx.mod <= '0;
          // A start coinciding with the done pulse is deliberately dropped.
          if (start && !done) begin
            len_q     <= (cfg_len < MIN_LEN_V) ? MIN_LEN_V : cfg_len;
            num_q     <= cfg_num;
            ipg_q     <= cfg_ipg;
            pkt_count <= '0;
            w_q       <= '0;
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (pkt_tx.full) begin
            pkt_tx.val <= 1'b0;
            pkt_tx.sop <= 1'b0;
            pkt_tx.eop <= 1'b0;
            pkt_tx.mod <= '0;
          end else begin
            pkt_tx.data <= word;
            pkt_tx.val  <= 1'b1;
            pkt_tx.sop  <= (w_q == '0);
            pkt_tx.eop  <= is_last;
            pkt_tx.mod  <= is_last ? len_q[2:0] : 3'd0;
            if (is_last) begin
              pkt_count <= pkt_count + 32'd1;
              w_q       <= '0;
              if (run_end) begin
                state <= DONE;
              end else if (ipg_q != 8'd0) begin
                ipg_cnt <= ipg_q;
                state   <= IPG;
              end
            end else begin
              w_q <= w_q + WIDX_W'(1);
            end
          end
        end
        IPG: begin
          pkt_tx.val <= 1'b0;
          pkt_tx.sop <= 1'b0;
          pkt_tx.eop <= 1'b0;
          pkt_tx.mod <= '0;
          if (stop) begin
            state <= DONE;
          end else if (ipg_cnt == 8'd1) begin
            state <= SEND;
          end else begin
            ipg_cnt <= ipg_cnt - 8'd1;
          end
        end
        DONE: begin
          pkt_tx.val <= 1'b0;
          pkt_tx.sop <= 1'b0;
          pkt_tx.eop <= 1'b0;
          pkt_tx.mod <= '0;
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_tx_gen.sv
// Bench for pkt_tx_gen: directed scenarios plus randomized runs, all word
// streams checked against a byte-level frame model built from the pattern rule.
module tb_pkt_tx_gen;
  import pkt_tx_gen_pkg::*;

  localparam int W = 69; // {sop, eop, mod[2:0], data[63:0]}

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [13:0] cfg_len = '0;
  logic [15:0] cfg_num = '0;
  logic [7:0]  cfg_ipg = '0;
  logic        busy;
  logic        done;
  logic [31:0] pkt_count;
  state_t      dbg_state;

  pkt_tx_gen_if pkt_tx ();

  pkt_tx_gen dut (
    .clk_156m25     (clk),
    .reset_156m25_n (rst_n),
    .start          (start),
    .stop           (stop),
    .cfg_len        (cfg_len),
    .cfg_num        (cfg_num),
    .cfg_ipg        (cfg_ipg),
    .pkt_tx         (pkt_tx.master),
    .busy           (busy),
    .done           (done),
    .pkt_count      (pkt_count),
    .dbg_state      (dbg_state)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- back-pressure driver ----------------
  logic force_full = 1'b0;
  logic stall_en = 1'b0;
  initial begin
    pkt_tx.full = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      pkt_tx.full = stall_en ? ($urandom_range(0, 3) == 0) : force_full;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cap_q[$];
  int           cap_cyc[$];
  int           done_cnt = 0;
  int           done_cyc = -1;
  logic         done_busy = 1'b1;
  int           start_cyc = 0;
  int           vectors = 0;
  int           errs = 0;
  logic [W-1:0] tmp;

  initial forever begin
    @(negedge clk);
    if (pkt_tx.val === 1'b1) begin
      cap_q.push_back({pkt_tx.sop, pkt_tx.eop, pkt_tx.mod, pkt_tx.data});
      cap_cyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc  = cyc;
      done_busy = busy;
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] cap_at(input int i);
    if (i < 0 || i >= cap_q.size()) return 'x;
    return cap_q[i];
  endfunction

  function automatic int cyc_at(input int i);
    if (i < 0 || i >= cap_cyc.size()) return -1000;
    return cap_cyc[i];
  endfunction

  // Reference model: frames are byte sequences (p + b) mod 256 packed 8 per word.
  task automatic build_exp(input int len, input int nfr);
    int l;
    int nw;
    logic [63:0] d;
    l  = (len < MIN_LEN) ? MIN_LEN : len;
    nw = (l + 7) / 8;
    exp_q.delete();
    for (int p = 0; p < nfr; p++) begin
      for (int w = 0; w < nw; w++) begin
        d = '0;
        for (int i = 0; i < 8; i++) begin
          if (w * 8 + i < l) d[63-8*i -: 8] = 8'((p + w * 8 + i) % 256);
        end
        exp_q.push_back({(w == 0), (w == nw - 1), (w == nw - 1) ? 3'(l % 8) : 3'd0, d});
      end
    end
  endtask

  task automatic clear_run();
    cap_q.delete();
    cap_cyc.delete();
    done_cnt  = 0;
    done_cyc  = -1;
    done_busy = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_start(input int len, input int num, input int ipg);
    cfg_len   = 14'(len);
    cfg_num   = 16'(num);
    cfg_ipg   = 8'(ipg);
    start     = 1'b1;
    start_cyc = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    int n0;
    k  = 0;
    n0 = done_cnt;
    while (done_cnt == n0 && k < budget) begin
      tick();
      k++;
    end
    check("done_timeout", 128'(done_cnt != n0), 128'(1));
  endtask

  task automatic wait_words(input int n, input int budget);
    int k;
    k = 0;
    while (cap_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("words_timeout", 128'(cap_q.size() >= n), 128'(1));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_val"}, pkt_tx.val, 0);
    check({tag, "_sop"}, pkt_tx.sop, 0);
    check({tag, "_eop"}, pkt_tx.eop, 0);
    check({tag, "_mod"}, pkt_tx.mod, 0);
    check({tag, "_data"}, pkt_tx.data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_count"}, pkt_count, 0);
  endtask

  task automatic check_run(input string tag, input int len, input int nfr, input int ipg, input bit stalled);
    int l;
    int nw;
    l  = (len < MIN_LEN) ? MIN_LEN : len;
    nw = (l + 7) / 8;
    build_exp(len, nfr);
    check({tag, "_word_count"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_word%0d", tag, i), cap_at(i), exp_q[i]);
    end
    if (!stalled) begin
      check({tag, "_sop_latency"}, cyc_at(0), start_cyc + 1);
      for (int f = 0; f < nfr; f++) begin
        check($sformatf("%s_span%0d", tag, f), cyc_at(f * nw + nw - 1) - cyc_at(f * nw), nw - 1);
        if (f > 0) check($sformatf("%s_gap%0d", tag, f), cyc_at(f * nw) - cyc_at(f * nw - 1), ipg + 1);
      end
    end
    check({tag, "_done_after_eop"}, done_cyc, cyc_at(exp_q.size() - 1) + 1);
    check({tag, "_busy_at_done"}, done_busy, 0);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_pkt_count"}, pkt_count, nfr);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int len;
    int num;
    int ipg;
    int nw;
    bit st;

    // Reset state
    repeat (3) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();
    check_outputs_zero("idle");
    check("idle_state", dbg_state, IDLE);

    // len=64, num=1, ipg=0
    clear_run();
    do_start(64, 1, 0);
    wait_done(100);
    repeat (3) tick();
    check_run("t1", 64, 1, 0, 0);
    check("t1_word0", cap_at(0), {2'b10, 3'd0, 64'h0001020304050607});
    check("t1_word7", cap_at(7), {2'b01, 3'd0, 64'h38393A3B3C3D3E3F});

    // len=65, num=2, ipg=3
    clear_run();
    do_start(65, 2, 3);
    wait_done(100);
    repeat (3) tick();
    check_run("t2", 65, 2, 3, 0);
    tmp = cap_at(8);
    check("t2_eop_data", tmp[63:0], 64'h4000000000000000);
    check("t2_eop_mod", tmp[66:64], 3'd1);
    tmp = cap_at(9);
    check("t2_f1_word0", tmp[63:0], 64'h0102030405060708);

    // len=5 clamps to 8: single word, sop=eop=1
    clear_run();
    do_start(5, 1, 0);
    wait_done(100);
    repeat (3) tick();
    check_run("t3", 5, 1, 0, 0);
    check("t3_word", cap_at(0), {2'b11, 3'd0, 64'h0001020304050607});

    // 5-cycle back-pressure mid-frame
    clear_run();
    do_start(64, 1, 0);
    wait_words(3, 50);
    force_full = 1'b1;
    repeat (5) tick();
    force_full = 1'b0;
    wait_done(100);
    repeat (3) tick();
    check_run("t4", 64, 1, 0, 1);
    check("t4_stall_span", cyc_at(7) - cyc_at(0), 7 + 5);

    // Continuous run, stop raised at word 3 of frame 2
    clear_run();
    do_start(64, 0, 0);
    wait_words(20, 100);
    stop = 1'b1;
    wait_done(100);
    stop = 1'b0;
    repeat (3) tick();
    check_run("t5", 64, 3, 0, 0);

    // Asynchronous reset mid-frame
    clear_run();
    do_start(64, 0, 0);
    repeat (5) tick();
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    check_outputs_zero("post_rst");

    // Start while busy and start during done are both ignored
    clear_run();
    do_start(64, 1, 0);
    repeat (3) tick();
    cfg_len = 14'd8;
    cfg_num = 16'd5;
    start   = 1'b1;
    tick();
    start = 1'b0;
    wait_done(100);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("t6_start_on_done_busy", busy, 0);
    check_run("t6", 64, 1, 0, 0);

    // Fresh start repeats the first run exactly
    clear_run();
    do_start(64, 1, 0);
    wait_done(100);
    repeat (3) tick();
    check_run("t7", 64, 1, 0, 0);
    check("t7_word0", cap_at(0), {2'b10, 3'd0, 64'h0001020304050607});
    check("t7_word7", cap_at(7), {2'b01, 3'd0, 64'h38393A3B3C3D3E3F});

    // Randomized runs, some under random back-pressure
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, 100);
      num = $urandom_range(1, 3);
      ipg = $urandom_range(0, 5);
      st  = 1'($urandom_range(0, 1));
      nw  = ((len < MIN_LEN ? MIN_LEN : len) + 7) / 8;
      clear_run();
      stall_en = st;
      do_start(len, num, ipg);
      wait_done(num * (nw * 8 + ipg + 10) + 50);
      stall_en = 1'b0;
      repeat (3) tick();
      check_run($sformatf("rnd%0d", r), len, num, ipg, st);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
